// File: rtl/imem_prog.sv
// Run-time loadable instruction memory for the LEGv8 fetch stage: registered fetch port plus a
// valid/ready load port. Define IMEM_PARITY_EN to store and check a per-word even-parity bit.
module imem_prog #(
  parameter int unsigned    N      = 32,
  parameter int unsigned    ADDR_W = 6,
  parameter int unsigned    DEPTH  = 64,
  parameter logic [N-1:0]   NOP    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [N-1:0]      q,
  output logic              q_valid,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [N-1:0]      ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic              par_err
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW     = N + 1;
  localparam logic [MemW-1:0] InitWord = {^NOP, NOP};
`else
  localparam int unsigned MemW     = N;
  localparam logic [MemW-1:0] InitWord = NOP;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [N-1:0]      q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              par_err_q, par_err_d;

  logic [MemW-1:0]   mem [DEPTH] = '{default: InitWord};
  logic              mem_we;
  logic [MemW-1:0]   wr_word;
  logic [MemW-1:0]   rd_ent;
  logic [N-1:0]      rd_word;
  logic              rd_err;
  logic              in_range;
  logic [ADDR_W:0]   len_clamp;

  assign rd_ent    = mem[addr];
  assign rd_word   = rd_ent[N-1:0];
  assign in_range  = ({1'b0, addr} < DepthW);
  assign len_clamp = (ld_len > DepthW) ? DepthW : ld_len;

`ifdef IMEM_PARITY_EN
  // Stored bit makes the whole entry even; any odd total is a corrupted entry.
  assign wr_word = {^ld_data, ld_data};
  assign rd_err  = ^rd_ent;
`else
  assign wr_word = ld_data;
  assign rd_err  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    par_err_d = par_err_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          wptr_d    = '0;
          cnt_d     = '0;
          len_d     = len_clamp;
          q_d       = NOP;
          q_valid_d = 1'b0;
          par_err_d = 1'b0;
          state_d   = (len_clamp == '0) ? StDone : StLoad;
        end else if (fetch_en) begin
          q_valid_d = 1'b1;
          q_d       = in_range ? rd_word : NOP;
          par_err_d = in_range & rd_err;
        end
      end
      StLoad: begin
        q_d       = NOP;
        q_valid_d = 1'b0;
        par_err_d = 1'b0;
        if (ld_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = StDone;
        end
      end
      StDone: begin
        q_d       = NOP;
        q_valid_d = 1'b0;
        par_err_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      q_q       <= NOP;
      q_valid_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      par_err_q <= par_err_d;
    end
  end

  // Contents survive reset so a partially loaded program is still visible afterwards.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= wr_word;
  end

  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign par_err  = par_err_q;
  assign ld_ready = (state_q == StLoad);
  assign ld_done  = (state_q == StDone);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_imem_prog.sv
// Randomized self-checking bench for imem_prog against an array model of the program memory.
module tb_imem_prog;
  localparam int N      = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_en = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [N-1:0]      q;
  logic              q_valid;
  logic              ld_start = 1'b0;
  logic [ADDR_W:0]   ld_len = '0;
  logic              ld_valid = 1'b0;
  logic [N-1:0]      ld_data = '0;
  logic              ld_ready;
  logic              ld_done;
  logic              busy;
  logic              par_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] plan [$];
  logic [31:0] none [$];

  imem_prog #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP('0)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_en (fetch_en),
    .addr     (addr),
    .q        (q),
    .q_valid  (q_valid),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .busy     (busy),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input int a);
    fetch_en = 1'b1;
    addr     = ADDR_W'(a);
    step();
    fetch_en = 1'b0;
    check_eq("fetch_q", q, model_mem[a]);
    check_eq("fetch_valid", 32'(q_valid), 32'd1);
    check_eq("fetch_par_err", 32'(par_err), 32'd0);
  endtask

  // Streams a load; abort_at >= 0 asserts reset once that many words have been accepted.
  task automatic do_load(input int len, input logic [31:0] words [$], input int min_gap,
                         input int max_gap, input int abort_at);
    int n;
    int idx;
    int gap;
    int guard;
    n     = (len > DEPTH) ? DEPTH : len;
    idx   = 0;
    guard = 0;
    ld_start = 1'b1;
    ld_len   = (ADDR_W + 1)'(len);
    fetch_en = 1'b1;
    addr     = ADDR_W'($urandom);
    step();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    check_eq("start_q_valid", 32'(q_valid), 32'd0);
    check_eq("start_q", q, 32'd0);
    check_eq("start_busy", 32'(busy), 32'd1);
    gap = $urandom_range(max_gap, min_gap);
    while (idx < n && guard < 2000) begin
      check_eq("load_ready", 32'(ld_ready), 32'd1);
      check_eq("load_done_low", 32'(ld_done), 32'd0);
      if (abort_at == idx) begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        #1;
        check_eq("abort_ready", 32'(ld_ready), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_q_valid", 32'(q_valid), 32'd0);
        check_eq("abort_done", 32'(ld_done), 32'd0);
        #2 reset = 1'b0;
        return;
      end
      fetch_en = 1'($urandom_range(0, 1));
      addr     = ADDR_W'($urandom);
      if (gap == 0) begin
        ld_valid = 1'b1;
        ld_data  = (idx < words.size()) ? words[idx] : $urandom;
      end else begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        gap--;
      end
      step();
      check_eq("load_q_valid", 32'(q_valid), 32'd0);
      if (ld_valid) begin
        model_mem[idx] = ld_data;
        idx++;
        gap = $urandom_range(max_gap, min_gap);
      end
      guard++;
    end
    ld_valid = 1'b0;
    fetch_en = 1'b0;
    check_eq("load_words", 32'(idx), 32'(n));
    check_eq("done_pulse", 32'(ld_done), 32'd1);
    check_eq("done_ready", 32'(ld_ready), 32'd0);
    check_eq("done_busy", 32'(busy), 32'd1);
    step();
    check_eq("idle_done", 32'(ld_done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_ready", 32'(ld_ready), 32'd0);
  endtask

  task automatic scan_all();
    for (int a = 0; a < DEPTH; a++) fetch_chk(a);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_q", q, 32'd0);
    check_eq("rst_q_valid", 32'(q_valid), 32'd0);
    check_eq("rst_ready", 32'(ld_ready), 32'd0);
    check_eq("rst_done", 32'(ld_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_par_err", 32'(par_err), 32'd0);
    reset = 1'b0;
    step();

    for (int a = 0; a < 4; a++) fetch_chk(a);
    step();
    check_eq("hold_q_valid", 32'(q_valid), 32'd1);
    check_eq("hold_q", q, model_mem[3]);

    plan.push_back(32'h8b0403e0);
    plan.push_back(32'h00000000);
    plan.push_back(32'hf80003e0);
    do_load(3, plan, 0, 0, -1);
    fetch_chk(0);
    fetch_chk(2);
    fetch_chk(1);

    do_load(4, none, 2, 2, -1);
    scan_all();
    do_load(0, none, 0, 0, -1);
    do_load(100, none, 0, 1, -1);
    scan_all();

    do_load(5, none, 0, 0, 2);
    step();
    check_eq("abort_no_done", 32'(ld_done), 32'd0);
    check_eq("abort_idle", 32'(busy), 32'd0);
    scan_all();

    for (int r = 0; r < 6; r++) begin
      do_load($urandom_range(0, 100), none, 0, $urandom_range(0, 3), -1);
      for (int k = 0; k < 10; k++) fetch_chk($urandom_range(0, DEPTH - 1));
    end
    scan_all();

`ifdef IMEM_PARITY_EN
    dut.mem[5][0] = ~dut.mem[5][0];
    fetch_en = 1'b1;
    addr     = 6'd5;
    step();
    fetch_en = 1'b0;
    check_eq("par_q", q, model_mem[5] ^ 32'd1);
    check_eq("par_err_set", 32'(par_err), 32'd1);
    fetch_chk(6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
